nd_base_counter: RTL



---
 rtl/nd_base_counter_if.sv | 15 +
 rtl/nd_base_counter.sv | 36 +++
 2 files changed

// File: rtl/nd_base_counter_if.sv
// nd_base_counter_if: control inputs and count outputs of one nd_base_counter instance
interface nd_base_counter_if #(
    parameter int N = 4,
    parameter int B = 10
);
    localparam int W = (B <= 2) ? 1 : $clog2(B);
    logic           m_ei;
    logic           m_up;
    logic           m_load;
    logic [N*W-1:0] m_d;
    logic           eu;
    logic [N*W-1:0] q;
    modport master (output m_ei, m_up, m_load, m_d, input eu, q);
    modport slave  (input m_ei, m_up, m_load, m_d, output eu, q);
endinterface

// File: rtl/nd_base_counter.sv
// nd_base_counter: N-digit base-B up/down counter with load and eu/m_ei cascading.
// Define ND_BASE_COUNTER_SAT_EN to saturate at terminal count instead of wrapping.
module nd_base_counter #(
    parameter int N = 4,
    parameter int B = 10
) (
    input  logic              m_clock,
    input  logic              m_reset,
    nd_base_counter_if.slave  bus
);
    localparam int W = (B <= 2) ? 1 : $clog2(B);
    localparam logic [W-1:0] MAX = W'(B - 1);
    logic [N-1:0][W-1:0] q_q, q_d;
    logic [N:0]          en;
    // en[i] enables digit i; en[N] means the whole counter is at terminal count and enabled
    always_comb begin
        en[0] = bus.m_ei;
        for (int i = 0; i < N; i++) begin
            en[i+1] = en[i] & (bus.m_up ? q_q[i] == MAX : q_q[i] == '0);
            q_d[i] = !en[i] ? q_q[i] :
                     bus.m_up ? (q_q[i] == MAX ? '0 : q_q[i] + 1'b1) :
                                (q_q[i] == '0 ? MAX : q_q[i] - 1'b1);
        end
`ifdef ND_BASE_COUNTER_SAT_EN
        if (en[N]) q_d = q_q;
`endif
        if (bus.m_load)
            for (int i = 0; i < N; i++)
                q_d[i] = (32'(bus.m_d[i*W +: W]) >= B) ? MAX : bus.m_d[i*W +: W];
    end
    always_ff @(posedge m_clock)
        if (m_reset) q_q <= '0;
        else q_q <= q_d;
    assign bus.eu = en[N] & ~bus.m_load;
    assign bus.q  = q_q;
endmodule
